// File: rtl/sub_b_rx.sv
// Strobe-qualified serial frame receiver.
// Start/data/parity frames in, valid/ready words out, sticky error flags.
module sub_b_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_data_b,
    input  logic              rx_strobe_b,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              par_err,
    output logic              ovr_err,
    output logic              to_err,
    input  logic              clr_err,
    output logic              busy
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY
    } state_t;

    state_t            r_state;
    logic [SYNC_STAGES-1:0] r_dsync;
    logic [SYNC_STAGES-1:0] r_ssync;
    logic              r_sprev;
    logic [DATA_W-1:0] r_shift;
    logic [CW-1:0]     r_bitcnt;
    logic [TW-1:0]     r_tmo;
    logic              r_busy;

    logic w_samp;
    logic w_bit;
    logic w_par_ok;
    logic w_accept;
    logic w_tc;
    logic w_last;

    // Data and strobe share the same depth so a bit stays aligned with its edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dsync <= '0;
            r_ssync <= '0;
            r_sprev <= 1'b0;
        end else begin
            r_dsync <= {r_dsync[SYNC_STAGES-2:0], rx_data_b};
            r_ssync <= {r_ssync[SYNC_STAGES-2:0], rx_strobe_b};
            r_sprev <= r_ssync[SYNC_STAGES-1];
        end
    end

    assign w_samp   = r_ssync[SYNC_STAGES-1] & ~r_sprev;
    assign w_bit    = r_dsync[SYNC_STAGES-1];
    assign w_par_ok = ((^r_shift) == w_bit);
    assign w_accept = ~out_valid | out_ready;
    assign w_tc     = (r_tmo == TW'(TIMEOUT - 1));
    assign w_last   = (r_bitcnt == CW'(DATA_W - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_tmo     <= '0;
            r_busy    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            par_err   <= 1'b0;
            ovr_err   <= 1'b0;
            to_err    <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // Clear first so a same-cycle error event below wins.
            if (clr_err) begin
                par_err <= 1'b0;
                ovr_err <= 1'b0;
                to_err  <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (w_samp && w_bit) begin
                        r_state  <= S_DATA;
                        r_busy   <= 1'b1;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                    end
                end
                S_DATA: begin
                    if (w_samp) begin
                        r_shift[r_bitcnt] <= w_bit;
                        r_tmo <= '0;
                        if (w_last) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end else if (w_tc) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_tmo   <= '0;
                        to_err  <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_samp) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_tmo   <= '0;
                        if (!w_par_ok) begin
                            par_err <= 1'b1;
                        end else if (w_accept) begin
                            out_data  <= r_shift;
                            out_valid <= 1'b1;
                        end else begin
                            ovr_err <= 1'b1;
                        end
                    end else if (w_tc) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_tmo   <= '0;
                        to_err  <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_tmo   <= '0;
                end
            endcase
        end
    end

    assign busy = r_busy;

endmodule

// File: tb/tb_sub_b_rx.sv
// Scoreboard bench for sub_b_rx: directed frames, queued expected words,
// negedge monitor popping on every accepted output word.
module tb_sub_b_rx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_data_b;
    logic       rx_strobe_b;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       par_err;
    logic       ovr_err;
    logic       to_err;
    logic       clr_err;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         valid_cycles = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    sub_b_rx #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(64)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_data_b(rx_data_b),
        .rx_strobe_b(rx_strobe_b),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .par_err(par_err),
        .ovr_err(ovr_err),
        .to_err(to_err),
        .clr_err(clr_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change 2ns after posedge, so negedge sees the
    // exact values the next rising edge will act on.
    always @(negedge clk) begin
        if (out_valid) valid_cycles++;
        if (prev_hold && out_valid) begin
            chk("data_stable", {24'h0, out_data}, {24'h0, prev_data});
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_word", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // One strobe period; clr_co asserts clr_err on the samp cycle.
    task automatic send_bit(input logic b, input bit clr_co = 1'b0);
        rx_data_b = b;
        tick(2);
        rx_strobe_b = 1'b1;
        tick(2);
        if (clr_co) clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        rx_strobe_b = 1'b0;
        tick(3);
    endtask

    task automatic send_data(input logic [7:0] w);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic p,
                              input bit clr_co = 1'b0);
        send_data(w);
        send_bit(p, clr_co);
    endtask

    initial begin
        reset_n     = 1'b0;
        rx_data_b   = 1'b0;
        rx_strobe_b = 1'b0;
        out_ready   = 1'b0;
        clr_err     = 1'b0;
        tick(3);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_data", {24'h0, out_data}, 32'h0);
        chk("rst_flags", {29'h0, par_err, ovr_err, to_err}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        reset_n = 1'b1;
        tick(2);

        // 1: 0xA5, latency of out_valid after the parity strobe edge
        exp_q.push_back(8'hA5);
        send_bit(1'b1);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        for (int i = 0; i < 8; i++) send_bit(logic'((8'hA5 >> i) & 1));
        rx_data_b = 1'b0;
        tick(2);
        rx_strobe_b = 1'b1;
        tick(2);
        chk("t1_valid_k1", {31'h0, out_valid}, 32'h0);
        tick(1);
        chk("t1_valid_k2", {31'h0, out_valid}, 32'h1);
        chk("t1_data", {24'h0, out_data}, 32'hA5);
        chk("t1_par", {31'h0, par_err}, 32'h0);
        chk("t1_idle", {31'h0, busy}, 32'h0);
        rx_strobe_b = 1'b0;
        tick(3);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("t1_drained", {31'h0, out_valid}, 32'h0);

        // 2: overrun
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0);
        send_frame(8'h3C, 1'b0);
        chk("t2_data", {24'h0, out_data}, 32'hA5);
        chk("t2_valid", {31'h0, out_valid}, 32'h1);
        chk("t2_ovr", {31'h0, ovr_err}, 32'h1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("t2_drained", {31'h0, out_valid}, 32'h0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t2_ovr_clr", {31'h0, ovr_err}, 32'h0);

        // 3: parity error, clear, then clear coincident with set
        out_ready = 1'b1;
        send_frame(8'h01, 1'b0);
        chk("t3_par", {31'h0, par_err}, 32'h1);
        chk("t3_valid", {31'h0, out_valid}, 32'h0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t3_par_clr", {31'h0, par_err}, 32'h0);
        send_frame(8'h01, 1'b0, 1'b1);
        chk("t3_par_wins", {31'h0, par_err}, 32'h1);
        chk("t3_ovr", {31'h0, ovr_err}, 32'h0);

        // 4: timeout then recovery
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t4_busy", {31'h0, busy}, 32'h1);
        tick(70);
        chk("t4_to", {31'h0, to_err}, 32'h1);
        chk("t4_idle", {31'h0, busy}, 32'h0);
        out_ready = 1'b0;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0);
        chk("t4_data", {24'h0, out_data}, 32'h5A);
        chk("t4_valid", {31'h0, out_valid}, 32'h1);

        // 5: async reset mid-frame
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", {31'h0, busy}, 32'h0);
        chk("t5_rst_data", {24'h0, out_data}, 32'h0);
        chk("t5_rst_flags", {29'h0, par_err, ovr_err, to_err}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        out_ready = 1'b1;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b0);
        chk("t5_flags", {29'h0, par_err, ovr_err, to_err}, 32'h0);
        chk("t5_data", {24'h0, out_data}, 32'hFF);

        // 6: zero-level strobes ignored, back-to-back frames
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b0);
            chk("t6_idle", {31'h0, busy}, 32'h0);
        end
        valid_cycles = 0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0);
        exp_q.push_back(8'h80);
        send_frame(8'h80, 1'b1);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b0);
        tick(3);
        chk("t6_valid_cycles", valid_cycles, 32'd3);
        chk("t6_flags", {29'h0, par_err, ovr_err, to_err}, 32'h0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sub_b_rx.md
Name: sub_b_rx

Overview:
Strobe-qualified serial frame receiver: the receive-side counterpart to the sub_a family transmit outputs (data line, strobe line).
- Synchronises both lines into the local clock domain and detects strobe rising edges.
- Deserialises start/data/parity frames and presents each word on a valid/ready output port.
- Reports parity, overrun and timeout errors as sticky flags.

Parameters:
DATA_W, 8, payload bits per frame (LSB first)
SYNC_STAGES, 2, flops per input synchroniser (min 2)
TIMEOUT, 64, max clk cycles between strobe edges inside a frame before abort

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  reset, asynchronous assert, active-low
rx_data_b  input  1  serial data line, asynchronous to clk
rx_strobe_b  input  1  sample strobe, asynchronous to clk; data sampled on its rising edge
out_data  output  DATA_W  received word
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts word when out_valid & out_ready at clk edge
par_err  output  1  sticky parity error
ovr_err  output  1  sticky overrun error
to_err  output  1  sticky frame timeout
clr_err  input  1  clears all sticky flags (one-cycle pulse)
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset_n low, async): out_data=0, out_valid=0, par_err=0, ovr_err=0, to_err=0, busy=0. Synchronisers, shift register and counters all 0; FSM=IDLE. Reset mid-frame discards the partial frame.
- Synchronisation:
  - rx_data_b and rx_strobe_b each pass through SYNC_STAGES flops, so they stay aligned.
  - An edge register on the synced strobe produces samp, a one-cycle pulse on a synced 0->1 transition.
  - The bit value is the synced data in the samp cycle.
  - Latency: a strobe edge set up before clk edge k gives samp high after edge k+SYNC_STAGES-1.
- FSM (acts only on samp, apart from timeout):
  - IDLE: samp with bit=1 is the start bit -> DATA, bit counter=0. samp with bit=0 is ignored. busy=0.
  - DATA: each samp shifts the bit into position bit counter (LSB first). After DATA_W bits -> PARITY.
  - PARITY: samp checks even parity, i.e. XOR(data bits) must equal the parity bit. Then -> IDLE.
    - Match with out_valid=0, or out_valid=1 & out_ready=1 in the same cycle: out_data<=word, out_valid<=1.
    - Match with out_valid=1 & out_ready=0: word dropped, out_data unchanged, ovr_err<=1.
    - Mismatch: word dropped, par_err<=1, out_valid/out_data unaffected.
- Output handshake:
  - out_valid rises the cycle after the parity samp, i.e. after edge k+SYNC_STAGES for the parity strobe edge.
  - out_valid falls the cycle after out_valid & out_ready.
  - out_data is stable while out_valid=1.
- Timeout:
  - Idle counter clears on every samp and in IDLE; it increments each cycle in DATA/PARITY.
  - Reaching TIMEOUT -> FSM=IDLE, partial word discarded, to_err<=1.
  - samp in the same cycle as the terminal count takes priority: the bit is accepted and the counter cleared.
- Error flags: clr_err clears all three flags. A flag-setting event in the same cycle as clr_err wins, so that flag reads 1 next cycle.
- busy = (FSM != IDLE).
- Strobe edges spaced closer than SYNC_STAGES+1 clk cycles are not guaranteed to be captured (source contract).

Test Plan:
1. Frame start=1, data 0xA5 LSB first, parity 0 -> out_data=0xA5; out_valid=1 at cycle k+2 after the parity strobe edge (SYNC_STAGES=2); par_err=0.
2. Hold out_ready=0, send 0xA5 then 0x3C (parity 0) -> out_data stays 0xA5, ovr_err=1. Then out_ready=1 for one cycle -> out_valid=0.
3. Send 0x01 with parity 0 (bad) -> par_err=1, out_valid stays 0. Then pulse clr_err -> par_err=0. Repeat with clr_err coincident with the bad-parity samp -> par_err=1.
4. Start plus 3 data bits, then no strobe for 64 cycles -> to_err=1, busy=0. Next full frame 0x5A (parity 0) -> out_data=0x5A, valid.
5. Assert reset_n=0 mid-frame after 4 data bits -> all outputs 0 immediately. Release, then full frame 0xFF (parity 0) -> out_data=0xFF with no errors.
6. Strobe edges at 0 level in IDLE (data=0) -> no state change, busy=0. Back-to-back frames with out_ready tied 1 -> each word valid exactly one cycle, no ovr_err.
